// File: rtl/regfile_operand_reader_if.sv
// Issue, register-file read, writeback and execute-side signals of the operand reader.
// master = surrounding pipeline/environment, slave = regfile_operand_reader.
interface regfile_operand_reader_if #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [4:0]             in_rd;
    logic                   in_rd_we;
    logic [4:0]             rf_pos1;
    logic [4:0]             rf_pos2;
    logic [DATA_W-1:0]      rf_value1;
    logic [DATA_W-1:0]      rf_value2;
    logic                   wb_valid;
    logic [4:0]             wb_pos;
    logic [DATA_W-1:0]      wb_value;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_op1;
    logic [DATA_W-1:0]      out_op2;
    logic [4:0]             out_rd;
    logic                   out_rd_we;
    logic [STALL_CNT_W-1:0] stall_count;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        input  rf_value1, rf_value2,
        input  wb_valid, wb_pos, wb_value,
        input  out_ready,
        output in_ready, rf_pos1, rf_pos2,
        output out_valid, out_op1, out_op2, out_rd, out_rd_we,
        output stall_count
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
        output rf_value1, rf_value2,
        output wb_valid, wb_pos, wb_value,
        output out_ready,
        input  in_ready, rf_pos1, rf_pos2,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_we,
        input  stall_count
    );
endinterface

// File: rtl/regfile_operand_reader.sv
// Decode-side register-file read client with scoreboard RAW stalls and a one-entry output register.
// Optional macro BYPASS_EN forwards same-cycle writeback data to the operands.
module regfile_operand_reader #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_operand_reader_if.slave bus
);

`ifdef BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0]            scoreboard;
    logic [31:0]            scoreboard_nxt;
    logic                   hazard;
    logic                   accept;
    logic                   rd_trackable;
    logic [DATA_W-1:0]      op1_sel;
    logic [DATA_W-1:0]      op2_sel;

    logic                   vld_p0;
    logic [DATA_W-1:0]      op1_p0;
    logic [DATA_W-1:0]      op2_p0;
    logic [4:0]             rd_p0;
    logic                   rd_we_p0;
    logic [STALL_CNT_W-1:0] stall_cnt;

    function automatic logic is_pending(input logic [31:0] sb, input logic [4:0] r,
                                        input logic wbv, input logic [4:0] wbp);
        return sb[r] && !(BYPASS && wbv && (wbp == r));
    endfunction

    // r31 writes are dropped by the RF, so forwarding them would return data that never lands.
    function automatic logic [DATA_W-1:0] select_operand(input logic [4:0] r,
                                                         input logic [DATA_W-1:0] rfv,
                                                         input logic wbv, input logic [4:0] wbp,
                                                         input logic [DATA_W-1:0] wbd);
        if (r == 5'd0)
            return '0;
        if (BYPASS && wbv && (wbp == r) && (r != 5'd31))
            return wbd;
        return rfv;
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
        return (&c) ? c : c + STALL_CNT_W'(1);
    endfunction

    assign bus.rf_pos1 = bus.in_rs1;
    assign bus.rf_pos2 = bus.in_rs2;

    assign hazard = bus.in_valid &&
                    (is_pending(scoreboard, bus.in_rs1, bus.wb_valid, bus.wb_pos) ||
                     is_pending(scoreboard, bus.in_rs2, bus.wb_valid, bus.wb_pos));

    assign bus.in_ready = !hazard && (!vld_p0 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign rd_trackable = (bus.in_rd != 5'd0) && (bus.in_rd != 5'd31);

    assign op1_sel = select_operand(bus.in_rs1, bus.rf_value1, bus.wb_valid, bus.wb_pos, bus.wb_value);
    assign op2_sel = select_operand(bus.in_rs2, bus.rf_value2, bus.wb_valid, bus.wb_pos, bus.wb_value);

    // Clear first, then set, so a new producer of the same register keeps it pending.
    always_comb begin
        scoreboard_nxt = scoreboard;
        if (bus.wb_valid)
            scoreboard_nxt[bus.wb_pos] = 1'b0;
        if (accept && bus.in_rd_we && rd_trackable)
            scoreboard_nxt[bus.in_rd] = 1'b1;
    end

    // ---- stage p0: resolved operands held for execute ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0     <= 1'b0;
            op1_p0     <= '0;
            op2_p0     <= '0;
            rd_p0      <= '0;
            rd_we_p0   <= 1'b0;
            scoreboard <= '0;
            stall_cnt  <= '0;
        end else begin
            scoreboard <= scoreboard_nxt;
            if (hazard)
                stall_cnt <= sat_inc(stall_cnt);
            if (accept) begin
                vld_p0   <= 1'b1;
                op1_p0   <= op1_sel;
                op2_p0   <= op2_sel;
                rd_p0    <= bus.in_rd;
                rd_we_p0 <= bus.in_rd_we && rd_trackable;
            end else if (bus.out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = vld_p0;
    assign bus.out_op1     = op1_p0;
    assign bus.out_op2     = op2_p0;
    assign bus.out_rd      = rd_p0;
    assign bus.out_rd_we   = rd_we_p0;
    assign bus.stall_count = stall_cnt;

endmodule
